// File: rtl/joypad_pkg.sv
// Shared types and constants for the NES joypad poller.
package joypad_pkg;

  localparam int unsigned NUM_BITS = 8;

  // Bit positions within a button byte, in controller shift order.
  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StSettle,
    StHigh,
    StLow,
    StDone
  } state_t;

endpackage

// File: rtl/joypad_sync_2ff.sv
// Two-flop synchroniser for the two asynchronous pad data lines.
module joypad_sync_2ff (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] d,
  output logic [1:0] q
);

  logic [1:0] meta;

  // Two back-to-back flops give metastability time to resolve.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/joypad_poller.sv
// Host-side NES controller poller: strobes both pads, clocks out 8 bits
// LSB-first and presents them as parallel button bytes.
// Optional macro JOYPAD_ACTIVE_LOW_EN: invert pad data (pads drive 0 = pressed).
module joypad_poller
  import joypad_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned POLL_INTERVAL = 200,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       poll_req,
  input  logic [1:0] pad_data,
  output logic       pad_strobe,
  output logic [1:0] pad_clock,
  output logic [7:0] buttons1,
  output logic [7:0] buttons2,
  output logic       valid,
  output logic       busy
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] ivl_q, ivl_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sr1_q, sr1_d, sr2_q, sr2_d;
  logic [7:0]       btn1_q, btn1_d, btn2_q, btn2_d;
  logic             strobe_q, clock_q, valid_q, busy_q;
  logic [1:0]       data_sync, sample;
  logic             phase_last, tick;

  joypad_sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pad_data),
    .q     (data_sync)
  );

`ifdef JOYPAD_ACTIVE_LOW_EN
  assign sample = ~data_sync;
`else
  assign sample = data_sync;
`endif

  assign phase_last = (phase_q == CNT_W'(CLK_DIV - 1));
  assign tick       = enable && (ivl_q == CNT_W'(POLL_INTERVAL - 1));

  // Interval counter: free-runs while enabled, wrap is the poll tick.
  always_comb begin
    ivl_d = '0;
    if (enable) begin
      ivl_d = tick ? '0 : ivl_q + CNT_W'(1);
    end
  end

  // Next-state, phase counting and bit capture.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q + CNT_W'(1);
    idx_d   = idx_q;
    sr1_d   = sr1_q;
    sr2_d   = sr2_q;
    btn1_d  = btn1_q;
    btn2_d  = btn2_q;
    case (state_q)
      StIdle: begin
        phase_d = '0;
        // Requests and ticks are only honoured here, so overlaps are dropped.
        if (poll_req || tick) begin
          state_d = StLatch;
          sr1_d   = '0;
          sr2_d   = '0;
        end
      end
      StLatch: begin
        if (phase_last) begin
          state_d = StSettle;
          phase_d = '0;
        end
      end
      StSettle: begin
        if (phase_last) begin
          state_d       = StHigh;
          phase_d       = '0;
          sr1_d[BTN_A]  = sample[0];
          sr2_d[BTN_A]  = sample[1];
          idx_d         = 3'(BTN_B);
        end
      end
      StHigh: begin
        if (phase_last) begin
          state_d = StLow;
          phase_d = '0;
        end
      end
      StLow: begin
        if (phase_last) begin
          phase_d      = '0;
          sr1_d[idx_q] = sample[0];
          sr2_d[idx_q] = sample[1];
          if (idx_q == 3'(NUM_BITS - 1)) begin
            state_d = StDone;
            // Load outputs on entry to DONE so they change together with valid.
            btn1_d  = sr1_d;
            btn2_d  = sr2_d;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = StHigh;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        phase_d = '0;
      end
      default: begin
        state_d = StIdle;
        phase_d = '0;
      end
    endcase
  end

  // State and datapath registers; pad outputs registered from next state to stay glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      phase_q  <= '0;
      ivl_q    <= '0;
      idx_q    <= '0;
      sr1_q    <= '0;
      sr2_q    <= '0;
      btn1_q   <= '0;
      btn2_q   <= '0;
      strobe_q <= 1'b0;
      clock_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      ivl_q    <= ivl_d;
      idx_q    <= idx_d;
      sr1_q    <= sr1_d;
      sr2_q    <= sr2_d;
      btn1_q   <= btn1_d;
      btn2_q   <= btn2_d;
      strobe_q <= (state_d == StLatch);
      clock_q  <= (state_d == StHigh);
      valid_q  <= (state_d == StDone);
      busy_q   <= (state_d != StIdle);
    end
  end

  assign pad_strobe = strobe_q;
  assign pad_clock  = {2{clock_q}};
  assign buttons1   = btn1_q;
  assign buttons2   = btn2_q;
  assign valid      = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_joypad_poller.sv
// Self-checking bench for joypad_poller with a behavioural two-pad controller model.
module tb_joypad_poller;

  localparam int unsigned CLK_DIV       = 4;
  localparam int unsigned POLL_INTERVAL = 200;
  localparam int          LAT           = 16 * CLK_DIV + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       poll_req = 1'b0;
  logic [1:0] pad_data;
  logic       pad_strobe;
  logic [1:0] pad_clock;
  logic [7:0] buttons1, buttons2;
  logic       valid, busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  joypad_poller #(
    .CLK_DIV       (CLK_DIV),
    .POLL_INTERVAL (POLL_INTERVAL),
    .CNT_W         (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .poll_req   (poll_req),
    .pad_data   (pad_data),
    .pad_strobe (pad_strobe),
    .pad_clock  (pad_clock),
    .buttons1   (buttons1),
    .buttons2   (buttons2),
    .valid      (valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: parallel load on strobe, shift right on falling clock.
  logic [7:0] pad1_val = 8'h00;
  logic [7:0] pad2_val = 8'h00;
  logic [7:0] sh1 = 8'h00;
  logic [7:0] sh2 = 8'h00;
  always @(posedge pad_strobe or negedge pad_clock[0]) begin
    if (pad_strobe) begin
      sh1 <= pad1_val;
      sh2 <= pad2_val;
    end else begin
      sh1 <= {1'b0, sh1[7:1]};
      sh2 <= {1'b0, sh2[7:1]};
    end
  end
`ifdef JOYPAD_ACTIVE_LOW_EN
  assign pad_data = ~{sh2[0], sh1[0]};
`else
  assign pad_data = {sh2[0], sh1[0]};
`endif

  // Event monitor: running counts consumed by the scenario tasks as deltas.
  int         strobe_cycles = 0, clock_rises = 0, busy_rises = 0;
  int         btn_glitches = 0, clk_split = 0;
  int         valid_times[$];
  logic       clk_prev = 1'b0, busy_prev = 1'b0;
  logic [15:0] btn_prev = '0;
  always @(negedge clk) begin
    if (pad_strobe) strobe_cycles <= strobe_cycles + 1;
    if (pad_clock[0] && !clk_prev) clock_rises <= clock_rises + 1;
    if (busy && !busy_prev) busy_rises <= busy_rises + 1;
    if (pad_clock[0] !== pad_clock[1]) clk_split <= clk_split + 1;
    if (!reset && !valid && ({buttons1, buttons2} !== btn_prev)) btn_glitches <= btn_glitches + 1;
    if (valid) valid_times.push_back(cyc);
    clk_prev  <= pad_clock[0];
    busy_prev <= busy;
    btn_prev  <= {buttons1, buttons2};
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Waits for the next valid pulse, driving mid-poll stimulus at given cycles.
  task automatic wait_valid(input int chg_at, input logic [7:0] c1, input logic [7:0] c2,
                            input int req_a, input int req_b, output int t, output bit ok);
    int n0 = valid_times.size();
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      step();
      poll_req = (cyc == req_a) || (cyc == req_b);
      if (cyc == chg_at) begin
        pad1_val = c1;
        pad2_val = c2;
      end
      if (valid_times.size() > n0) begin
        ok = 1'b1;
        t  = valid_times[n0];
      end
    end
    poll_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    vectors++; if (pad_strobe !== 1'b0) begin miscompares++; $display("FAIL rst_strobe: got %b want 0", pad_strobe); end
    vectors++; if (pad_clock !== 2'b00) begin miscompares++; $display("FAIL rst_clock: got %b want 00", pad_clock); end
    vectors++; if (buttons1 !== 8'h00) begin miscompares++; $display("FAIL rst_btn1: got %h want 00", buttons1); end
    vectors++; if (buttons2 !== 8'h00) begin miscompares++; $display("FAIL rst_btn2: got %h want 00", buttons2); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    reset = 1'b0;
    repeat (300) step();
    vectors++;
    if (valid_times.size() != 0) begin
      miscompares++; $display("FAIL idle_no_poll: got %0d polls want 0", valid_times.size());
    end
  endtask

  // One manually requested poll with the given pad bytes, fully checked.
  task automatic test_poll(input logic [7:0] v1, input logic [7:0] v2);
    int s, t, s0, c0, b0;
    bit ok;
    pad1_val = v1;
    pad2_val = v2;
    s0 = strobe_cycles; c0 = clock_rises; b0 = busy_rises;
    poll_req = 1'b1;
    s = cyc;
    wait_valid(-1, 8'h00, 8'h00, -1, -1, t, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL poll_timeout: got none want valid"); end
    vectors++; if (t - s != LAT) begin miscompares++; $display("FAIL poll_latency: got %0d want %0d", t - s, LAT); end
    vectors++;
    if ({buttons1, buttons2} !== {v1, v2}) begin
      miscompares++; $display("FAIL poll_buttons: got %h/%h want %h/%h", buttons1, buttons2, v1, v2);
    end
    vectors++; if (strobe_cycles - s0 != CLK_DIV) begin miscompares++; $display("FAIL poll_strobe_len: got %0d want %0d", strobe_cycles - s0, CLK_DIV); end
    vectors++; if (clock_rises - c0 != 7) begin miscompares++; $display("FAIL poll_clock_pulses: got %0d want 7", clock_rises - c0); end
    vectors++; if (busy_rises - b0 != 1) begin miscompares++; $display("FAIL poll_busy_rises: got %0d want 1", busy_rises - b0); end
    step();
    vectors++; if ({valid, busy} !== 2'b00) begin miscompares++; $display("FAIL poll_after: got valid,busy=%b want 00", {valid, busy}); end
  endtask

  task automatic test_mid_change();
    int s, t;
    bit ok;
    pad1_val = 8'hA5;
    pad2_val = 8'h3C;
    poll_req = 1'b1;
    s = cyc;
    wait_valid(s + 10, 8'hFF, 8'h00, -1, -1, t, ok);
    vectors++;
    if (!ok || {buttons1, buttons2} !== 16'hA53C) begin
      miscompares++; $display("FAIL mid_change_latched: got %h/%h want a5/3c", buttons1, buttons2);
    end
    step();
    test_poll(8'hFF, 8'h00);
  endtask

  task automatic test_reset_mid_poll();
    int s, n0;
    logic [7:0] v1, v2;
    pad1_val = $urandom;
    pad2_val = $urandom;
    n0 = valid_times.size();
    poll_req = 1'b1;
    s = cyc;
    step();
    poll_req = 1'b0;
    while (cyc < s + 26) step();
    vectors++; if (pad_clock !== 2'b11) begin miscompares++; $display("FAIL mid_rst_in_high: got %b want 11", pad_clock); end
    reset = 1'b1;
    #1;
    vectors++;
    if ({pad_strobe, pad_clock, busy, valid, buttons1, buttons2} !== 21'd0) begin
      miscompares++;
      $display("FAIL mid_rst_clear: got s=%b c=%b b=%b v=%b %h/%h want all 0",
               pad_strobe, pad_clock, busy, valid, buttons1, buttons2);
    end
    repeat (3) step();
    reset = 1'b0;
    repeat (100) step();
    vectors++;
    if (valid_times.size() != n0) begin
      miscompares++; $display("FAIL mid_rst_no_valid: got %0d pulses want 0", valid_times.size() - n0);
    end
    v1 = $urandom; v2 = $urandom;
    test_poll(v1, v2);
  endtask

  task automatic test_back_to_back();
    int s, t, s0, b0, n0;
    bit ok;
    logic [7:0] v1, v2;
    v1 = $urandom; v2 = $urandom;
    pad1_val = v1; pad2_val = v2;
    s0 = strobe_cycles; b0 = busy_rises; n0 = valid_times.size();
    poll_req = 1'b1;
    s = cyc;
    wait_valid(-1, 8'h00, 8'h00, s + 5, s + 40, t, ok);
    vectors++;
    if (!ok || t - s != LAT || {buttons1, buttons2} !== {v1, v2}) begin
      miscompares++; $display("FAIL b2b_poll: got lat=%0d %h/%h want lat=%0d %h/%h", t - s, buttons1, buttons2, LAT, v1, v2);
    end
    repeat (100) step();
    vectors++; if (valid_times.size() - n0 != 1) begin miscompares++; $display("FAIL b2b_valid_count: got %0d want 1", valid_times.size() - n0); end
    vectors++; if (strobe_cycles - s0 != CLK_DIV) begin miscompares++; $display("FAIL b2b_strobe: got %0d want %0d", strobe_cycles - s0, CLK_DIV); end
    vectors++; if (busy_rises - b0 != 1) begin miscompares++; $display("FAIL b2b_busy: got %0d want 1", busy_rises - b0); end
  endtask

  task automatic test_periodic();
    int n0, got, bcyc, t, n1;
    bit ok;
    logic [7:0] e1, e2;
    e1 = $urandom; e2 = $urandom;
    pad1_val = e1; pad2_val = e2;
    n0 = valid_times.size();
    got = 0;
    enable = 1'b1;
    for (int i = 0; i < 1500 && got < 5; i++) begin
      step();
      if (valid_times.size() > n0 + got) begin
        vectors++;
        if ({buttons1, buttons2} !== {e1, e2}) begin
          miscompares++; $display("FAIL periodic_buttons: got %h/%h want %h/%h", buttons1, buttons2, e1, e2);
        end
        got++;
        e1 = $urandom; e2 = $urandom;
        pad1_val = e1; pad2_val = e2;
      end
    end
    vectors++; if (got != 5) begin miscompares++; $display("FAIL periodic_count: got %0d want 5", got); end
    for (int k = 1; k < got; k++) begin
      vectors++;
      if (valid_times[n0 + k] - valid_times[n0 + k - 1] != POLL_INTERVAL) begin
        miscompares++;
        $display("FAIL periodic_spacing: got %0d want %0d", valid_times[n0 + k] - valid_times[n0 + k - 1], POLL_INTERVAL);
      end
    end
    // Disable partway through the next poll: it must still complete.
    bcyc = -1;
    for (int i = 0; i < 250 && bcyc < 0; i++) begin
      step();
      if (busy) bcyc = cyc;
    end
    repeat (10) step();
    enable = 1'b0;
    wait_valid(-1, 8'h00, 8'h00, -1, -1, t, ok);
    vectors++;
    if (bcyc < 0 || !ok || t - bcyc != LAT - 1 || {buttons1, buttons2} !== {e1, e2}) begin
      miscompares++;
      $display("FAIL disable_mid_poll: got lat=%0d %h/%h want lat=%0d %h/%h", t - bcyc, buttons1, buttons2, LAT - 1, e1, e2);
    end
    n1 = valid_times.size();
    repeat (500) step();
    vectors++; if (valid_times.size() != n1) begin miscompares++; $display("FAIL disabled_no_poll: got %0d want 0", valid_times.size() - n1); end
  endtask

  task automatic test_integrity();
    vectors++; if (btn_glitches != 0) begin miscompares++; $display("FAIL button_glitch: got %0d want 0", btn_glitches); end
    vectors++; if (clk_split != 0) begin miscompares++; $display("FAIL clock_bits_equal: got %0d want 0", clk_split); end
  endtask

  initial begin
    logic [7:0] r1, r2;
    test_reset();
    test_poll(8'hA5, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      r1 = $urandom; r2 = $urandom;
      test_poll(r1, r2);
    end
    test_mid_change();
    test_reset_mid_poll();
    test_back_to_back();
    test_periodic();
    test_integrity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
